// File: rtl/mcp3008_responder.sv
// ---------------------------------------------------------------------------
// mcp3008_responder
//
// SPI responder that answers MCP3008-style ADC polling frames with codes
// taken from a parallel channel bus.
// The SPI lines are oversampled on the system clock.
//
// Ports:
//   clk        system clock (50 MHz), AD_CLK must be >= 8x slower
//   rst_n      async active-low reset; release synchronised to clk
//   ad_clk     SPI SCLK from the master (asynchronous)
//   cs         chip select, active low (asynchronous)
//   din        master -> responder data (asynchronous)
//   dout       responder -> master data
//   dout_oe    pad output enable, 0 = high-Z
//   ch_data    eight CODE_W-bit channel codes, CHn = ch_data[10n+9:10n]
//   busy       frame in progress (cs low and start bit seen)
//   conv_done  one-clk pulse after B0 has been driven
//   last_cfg   {SGL/DIFF, D2, D1, D0} of the last completed frame
//   last_code  code returned in the last completed frame
//   frame_err  sticky: cs rose between start bit and B0
//
// Build option: define MCP3008_LSB_TRAIL_EN to repeat B1..B9 LSB-first
// after B0, as the real part does. Undefined: dout stays 0 after B0.
// ---------------------------------------------------------------------------
module mcp3008_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int CODE_W      = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ad_clk,
    input  logic                  cs,
    input  logic                  din,
    output logic                  dout,
    output logic                  dout_oe,
    input  logic [8*CODE_W-1:0]   ch_data,
    output logic                  busy,
    output logic                  conv_done,
    output logic [3:0]            last_cfg,
    output logic [CODE_W-1:0]     last_code,
    output logic                  frame_err
);

    if (CODE_W != 10) begin : g_bad_code_w
        $error("mcp3008_responder: CODE_W must be 10");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("mcp3008_responder: SYNC_STAGES must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        WSTART,
        CFG,
        NULLB,
        DATA,
        TRAIL
    } state_t;

    // -----------------------------------------------------------------------
    // Reset: assert asynchronously, release on a clk edge.
    // -----------------------------------------------------------------------
    logic [1:0] rst_pipe;
    logic       rst_sync_n;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_pipe <= 2'b00;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_sync_n = rst_pipe[1];

    // -----------------------------------------------------------------------
    // Input synchronisers and edge strobes.
    // Strobes are registered, giving SYNC_STAGES+1 clk from pin to strobe.
    // din_bit is the din value from just before the SCLK edge was seen, so a
    // master that updates DIN right at the rising edge is still read right.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, din_sync;
    logic sclk_q, din_q, cs_q;
    logic sclk_rise, sclk_fall, din_bit, cs_r, cs_fall;

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            din_sync  <= '0;
            sclk_q    <= 1'b0;
            din_q     <= 1'b0;
            cs_q      <= 1'b1;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            din_bit   <= 1'b0;
            cs_r      <= 1'b1;
            cs_fall   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], ad_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], din};
            sclk_q    <= sclk_sync[SYNC_STAGES-1];
            din_q     <= din_sync[SYNC_STAGES-1];
            cs_q      <= cs_sync[SYNC_STAGES-1];
            sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_q;
            sclk_fall <= ~sclk_sync[SYNC_STAGES-1] & sclk_q;
            din_bit   <= din_q;
            cs_r      <= cs_sync[SYNC_STAGES-1];
            cs_fall   <= ~cs_sync[SYNC_STAGES-1] & cs_q;
        end
    end

    // -----------------------------------------------------------------------
    // Channel selection.
    // -----------------------------------------------------------------------
    logic [CODE_W-1:0] ch [8];
    for (genvar i = 0; i < 8; i++) begin : g_ch
        assign ch[i] = ch_data[i*CODE_W +: CODE_W];
    end

    logic [3:0]        cfg_q, cfg_d;
    logic [CODE_W-1:0] in_p, in_n, sel_code;
    logic [CODE_W:0]   diff;

    always_comb begin
        in_p = ch[{cfg_q[2:1], cfg_q[0]}];
        in_n = ch[{cfg_q[2:1], ~cfg_q[0]}];
        // Extra bit catches IN- > IN+, which must clamp to 0 rather than wrap.
        diff = {1'b0, in_p} - {1'b0, in_n};
        if (cfg_q[3])     sel_code = ch[cfg_q[2:0]];
        else if (diff[CODE_W]) sel_code = '0;
        else              sel_code = diff[CODE_W-1:0];
    end

    // -----------------------------------------------------------------------
    // Frame FSM and datapath registers.
    // -----------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [CODE_W-1:0] sample_q, sample_d;
    logic              dout_q, dout_d;
    logic              oe_q, oe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [3:0]        lcfg_q, lcfg_d;
    logic [CODE_W-1:0] lcode_q, lcode_d;
    logic              ferr_q, ferr_d;

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q  <= IDLE;
            cfg_q    <= '0;
            cnt_q    <= '0;
            sample_q <= '0;
            dout_q   <= 1'b0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            lcfg_q   <= '0;
            lcode_q  <= '0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            dout_q   <= dout_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            lcfg_q   <= lcfg_d;
            lcode_q  <= lcode_d;
            ferr_q   <= ferr_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case below can leave a value unassigned (no latches).
        state_d  = state_q;
        cfg_d    = cfg_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        dout_d   = dout_q;
        oe_d     = oe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        lcfg_d   = lcfg_q;
        lcode_d  = lcode_q;
        ferr_d   = ferr_q;

        if (cs_r) begin
            // Deselect overrides everything; an abort mid-conversion is sticky.
            state_d = IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            dout_d  = 1'b0;
            if (state_q == CFG || state_q == NULLB || state_q == DATA)
                ferr_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d = WSTART;
                        oe_d    = 1'b1;
                        dout_d  = 1'b0;
                    end
                end
                WSTART: begin
                    if (sclk_rise && din_bit) begin
                        state_d = CFG;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                    end
                end
                CFG: begin
                    if (sclk_rise) begin
                        cfg_d = {cfg_q[2:0], din_bit};
                        if (cnt_q == 4'd3) state_d = NULLB;
                        else               cnt_d   = cnt_q + 4'd1;
                    end
                end
                NULLB: begin
                    if (sclk_fall) begin
                        sample_d = sel_code;
                        dout_d   = 1'b0;
                        cnt_d    = 4'd9;
                        state_d  = DATA;
                    end
                end
                DATA: begin
                    if (sclk_fall) begin
                        dout_d = sample_q[cnt_q];
                        if (cnt_q == 4'd0) begin
                            done_d  = 1'b1;
                            lcfg_d  = cfg_q;
                            lcode_d = sample_q;
                            busy_d  = 1'b0;
                            cnt_d   = 4'd1;
                            state_d = TRAIL;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                end
                TRAIL: begin
                    if (sclk_fall) begin
`ifdef MCP3008_LSB_TRAIL_EN
                        if (cnt_q < 4'd10) begin
                            dout_d = sample_q[cnt_q];
                            cnt_d  = cnt_q + 4'd1;
                        end else begin
                            dout_d = 1'b0;
                        end
`else
                        dout_d = 1'b0;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign dout      = dout_q;
    assign dout_oe   = oe_q;
    assign busy      = busy_q;
    assign conv_done = done_q;
    assign last_cfg  = lcfg_q;
    assign last_code = lcode_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_mcp3008_responder.sv
// ---------------------------------------------------------------------------
// tb_mcp3008_responder
//
// Directed bench for mcp3008_responder: a table of single-ended and
// pseudo-differential frames, then hand-written sequences for aborted
// frames, ch_data changing after the sample point, the trailing bits and
// reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_mcp3008_responder;

    localparam int HALF = 8;   // clk cycles per SCLK half period

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ad_clk;
    logic        cs;
    logic        din;
    logic [79:0] ch_base;
    logic        toggle_en;
    logic        tog = 1'b0;
    logic [79:0] ch_data;
    logic        dout;
    logic        dout_oe;
    logic        busy;
    logic        conv_done;
    logic [3:0]  last_cfg;
    logic [9:0]  last_code;
    logic        frame_err;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;

    bit reads   [32];
    bit oe_seen [32];
    bit busy_seen [32];

    always #10 clk = ~clk;
    always @(posedge clk) tog <= ~tog;
    always @(posedge clk) if (conv_done === 1'b1) done_cnt <= done_cnt + 1;

    assign ch_data = toggle_en ? (ch_base ^ {80{tog}}) : ch_base;

    mcp3008_responder #(.SYNC_STAGES(2), .CODE_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ad_clk    (ad_clk),
        .cs        (cs),
        .din       (din),
        .dout      (dout),
        .dout_oe   (dout_oe),
        .ch_data   (ch_data),
        .busy      (busy),
        .conv_done (conv_done),
        .last_cfg  (last_cfg),
        .last_code (last_code),
        .frame_err (frame_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One SCLK period: DIN set during the low phase, DOUT read just before
    // the rise (it carries the bit driven on the previous fall).
    task automatic sclk_cycle(input bit v, input int k);
        din = v;
        repeat (HALF) @(negedge clk);
        reads[k]     = dout;
        oe_seen[k]   = dout_oe;
        busy_seen[k] = busy;
        ad_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        ad_clk = 1'b0;
    endtask

    // Cycle 1 carries the start bit, 2..5 the config, 6 reads the null bit,
    // 7..16 read B9..B0, 17.. read trailing bits.
    task automatic frame(input logic [3:0] cfg_v, input int lead, input int ncyc, input bit tog_req);
        @(negedge clk) cs = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < lead; i++) sclk_cycle(1'b0, 0);
        sclk_cycle(1'b1, 1);
        for (int k = 2; k <= 5; k++) sclk_cycle(cfg_v[5-k], k);
        if (tog_req) begin
            repeat (6) @(negedge clk);
            toggle_en = 1'b1;
        end
        for (int k = 6; k <= ncyc; k++) sclk_cycle(1'b0, k);
        din = 1'b0;
    endtask

    task automatic end_frame();
        @(negedge clk) cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    function automatic logic [9:0] read_code();
        logic [9:0] c = '0;
        for (int b = 0; b < 10; b++) c = {c[8:0], reads[7+b]};
        return c;
    endfunction

    typedef struct {
        logic [3:0]  cfg;
        logic [79:0] ch;
        int          lead;
        logic [9:0]  code;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int d0;
        logic [9:0] prev_code;
        logic [9:0] trail_src;

        for (int i = 0; i < 8; i++) tbl[i].ch = '0;
        tbl[0].cfg = 4'b1101; tbl[0].ch[50 +: 10] = 10'h2A7; tbl[0].lead = 0; tbl[0].code = 10'h2A7;
        tbl[1].cfg = 4'b1101; tbl[1].ch[50 +: 10] = 10'h2A7; tbl[1].lead = 7; tbl[1].code = 10'h2A7;
        tbl[2].cfg = 4'b0010; tbl[2].ch[20 +: 10] = 10'd600; tbl[2].ch[30 +: 10] = 10'd250;
        tbl[2].lead = 0; tbl[2].code = 10'd350;
        tbl[3].cfg = 4'b0010; tbl[3].ch[20 +: 10] = 10'd100; tbl[3].ch[30 +: 10] = 10'd250;
        tbl[3].lead = 0; tbl[3].code = 10'd0;
        tbl[4].cfg = 4'b0011; tbl[4].ch[20 +: 10] = 10'd100; tbl[4].ch[30 +: 10] = 10'd250;
        tbl[4].lead = 2; tbl[4].code = 10'd150;
        tbl[5].cfg = 4'b1000; tbl[5].ch[0 +: 10] = 10'h3FF; tbl[5].ch[10 +: 10] = 10'h155;
        tbl[5].lead = 0; tbl[5].code = 10'h3FF;
        tbl[6].cfg = 4'b0110; tbl[6].ch[60 +: 10] = 10'd1023; tbl[6].ch[70 +: 10] = 10'd0;
        tbl[6].lead = 0; tbl[6].code = 10'd1023;
        tbl[7].cfg = 4'b1111; tbl[7].ch[70 +: 10] = 10'h001; tbl[7].ch[60 +: 10] = 10'h3FE;
        tbl[7].lead = 1; tbl[7].code = 10'h001;

        rst_n = 1'b0; ad_clk = 1'b0; cs = 1'b1; din = 1'b0;
        ch_base = '0; toggle_en = 1'b0;
        repeat (5) @(negedge clk);
        check("reset dout",      32'(dout), 0);
        check("reset dout_oe",   32'(dout_oe), 0);
        check("reset busy",      32'(busy), 0);
        check("reset conv_done", 32'(conv_done), 0);
        check("reset last_cfg",  32'(last_cfg), 0);
        check("reset last_code", 32'(last_code), 0);
        check("reset frame_err", 32'(frame_err), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // ---- table of complete frames ----
        for (int v = 0; v < 8; v++) begin
            ch_base = tbl[v].ch;
            d0 = done_cnt;
            frame(tbl[v].cfg, tbl[v].lead, 16, 1'b0);
            check($sformatf("v%0d busy before start", v), 32'(busy_seen[1]), 0);
            check($sformatf("v%0d dout_oe in frame", v), 32'(oe_seen[3]), 1);
            check($sformatf("v%0d busy in frame", v), 32'(busy_seen[8]), 1);
            check($sformatf("v%0d null bit", v), 32'(reads[6]), 0);
            check($sformatf("v%0d code read", v), 32'(read_code()), 32'(tbl[v].code));
            check($sformatf("v%0d last_code", v), 32'(last_code), 32'(tbl[v].code));
            check($sformatf("v%0d last_cfg", v), 32'(last_cfg), 32'(tbl[v].cfg));
            check($sformatf("v%0d conv_done pulses", v), 32'(done_cnt - d0), 1);
            check($sformatf("v%0d busy after B0", v), 32'(busy), 0);
            check($sformatf("v%0d frame_err", v), 32'(frame_err), 0);
            end_frame();
            check($sformatf("v%0d dout_oe after cs", v), 32'(dout_oe), 0);
        end
        prev_code = tbl[7].code;

        // ---- cs raised after three data bits ----
        ch_base = '0;
        ch_base[50 +: 10] = 10'h2A7;
        d0 = done_cnt;
        frame(4'b1101, 0, 8, 1'b0);
        @(negedge clk) cs = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort dout_oe", 32'(dout_oe), 0);
        check("abort frame_err", 32'(frame_err), 1);
        check("abort busy", 32'(busy), 0);
        check("abort last_code", 32'(last_code), 32'(prev_code));
        check("abort no conv_done", 32'(done_cnt - d0), 0);
        repeat (8) @(negedge clk);
        frame(4'b1101, 0, 16, 1'b0);
        check("after abort code", 32'(read_code()), 32'h2A7);
        check("after abort last_code", 32'(last_code), 32'h2A7);
        check("frame_err sticky", 32'(frame_err), 1);
        end_frame();

        // ---- ch_data toggling after the sample point ----
        ch_base = '0;
        ch_base[50 +: 10] = 10'h2A7;
        frame(4'b1101, 0, 16, 1'b1);
        toggle_en = 1'b0;
        check("toggle code read", 32'(read_code()), 32'h2A7);
        check("toggle last_code", 32'(last_code), 32'h2A7);
        end_frame();

        // ---- trailing bits after B0 ----
        trail_src = 10'h2A7;
        frame(4'b1101, 0, 26, 1'b0);
        for (int j = 0; j < 9; j++) begin
`ifdef MCP3008_LSB_TRAIL_EN
            check($sformatf("trail B%0d", j+1), 32'(reads[17+j]), 32'(trail_src[j+1]));
`else
            check($sformatf("trail bit %0d", j+1), 32'(reads[17+j]), 0);
`endif
        end
        check("trail after B9", 32'(reads[26]), 0);
        check("trail last_code", 32'(last_code), 32'(trail_src));
        end_frame();

        // ---- reset in the middle of a frame ----
        frame(4'b1101, 0, 10, 1'b0);
        check("pre-reset busy", 32'(busy), 1);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("mid reset dout_oe", 32'(dout_oe), 0);
        check("mid reset busy", 32'(busy), 0);
        check("mid reset dout", 32'(dout), 0);
        check("mid reset frame_err", 32'(frame_err), 0);
        check("mid reset last_code", 32'(last_code), 0);
        check("mid reset last_cfg", 32'(last_cfg), 0);
        cs = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        ch_base = '0;
        ch_base[20 +: 10] = 10'd600;
        ch_base[30 +: 10] = 10'd250;
        frame(4'b0010, 0, 16, 1'b0);
        check("post reset code", 32'(read_code()), 32'd350);
        check("post reset frame_err", 32'(frame_err), 0);
        end_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
